// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: default stage widths and the occupancy state
// encoding used by the pipeline stages.
package pipe_stage_skid_pkg;

    localparam int unsigned PIPE_DATA_W = 128;
    localparam int unsigned PIPE_CTRL_W = 8;
    localparam int unsigned PIPE_ST_W   = 2;

    // Encoding equals the number of held beats, so count_o is the state itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline entry: valid + control + payload register with load and clear.
// Control bits are held at zero whenever the entry is not valid.
module pipe_slot
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
        end else if (load_i) begin
            valid_o <= valid_i;
            ctrl_o  <= valid_i ? ctrl_i : '0;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with optional two-entry skid buffer; the skid
// variant breaks the combinational ready path from downstream.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic [PIPE_ST_W-1:0] state_q;
    logic [PIPE_ST_W-1:0] state_d;

    logic              accept;
    logic              xfer;
    logic              head_load;
    logic              head_valid_in;
    logic              head_from_skid;
    logic              skid_load;
    logic              skid_valid_in;
    logic [CTRL_W-1:0] head_ctrl_in;
    logic [DATA_W-1:0] head_data_in;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign accept  = in_valid_i & in_ready_o;
    assign xfer    = out_valid_o & out_ready_i;
    assign count_o = state_q;

    assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl_i;
    assign head_data_in = head_from_skid ? skid_data : in_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions; flush overrides any accept or transfer.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_valid_in  = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_valid_in  = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d       = ST_ONE;
                        head_load     = 1'b1;
                        head_valid_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !xfer) begin
                        state_d       = ST_TWO;
                        skid_load     = 1'b1;
                        skid_valid_in = 1'b1;
                    end else if (accept && xfer) begin
                        head_load     = 1'b1;
                        head_valid_in = 1'b1;
                    end else if (xfer) begin
                        state_d       = ST_EMPTY;
                        head_load     = 1'b1;
                        head_valid_in = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        state_d        = ST_ONE;
                        head_load      = 1'b1;
                        head_valid_in  = 1'b1;
                        head_from_skid = 1'b1;
                        skid_load      = 1'b1;
                        skid_valid_in  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .load_i  (head_load),
        .valid_i (head_valid_in),
        .ctrl_i  (head_ctrl_in),
        .data_i  (head_data_in),
        .valid_o (out_valid_o),
        .ctrl_o  (out_ctrl_o),
        .data_o  (out_data_o)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;
            logic skid_valid_unused;

            // Ready looks only at the next occupancy, never at out_ready_i directly.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != ST_TWO);
                end
            end

            assign in_ready_o = ready_q;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clear_i (flush_i),
                .load_i  (skid_load),
                .valid_i (skid_valid_in),
                .ctrl_i  (in_ctrl_i),
                .data_i  (in_data_i),
                .valid_o (skid_valid_unused),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );
        end else begin : g_single
            logic unused_skid;

            assign in_ready_o  = ~out_valid_o | out_ready_i;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign unused_skid = ^{skid_load, skid_valid_in};
        end
    endgenerate

endmodule
